instruction_fetch_unit: RTL

//   Upstream stage of the JericallaEvo datapath. Holds a small loadable program

---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: a loadable program memory streamed to the execute core
// one 17-bit word per clock, with stall, branch redirect/flush, halt word and fetch counter.
module instruction_fetch_unit #(
  parameter int                     INSTR_WIDTH = 17,
  parameter int                     PC_WIDTH    = 5,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 17'h1FFFF,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   prog_we,
  input  logic [PC_WIDTH-1:0]    prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  localparam int DEPTH = 1 << PC_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [INSTR_WIDTH-1:0] mem [0:DEPTH-1];
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   mem_we;

  // The program can only be changed while the stream is stopped.
  assign mem_we     = prog_we && (state != S_FETCH);
  assign fetch_word = mem[fetch_pc];

  // NOTE: the program memory deliberately has no reset, so its contents survive
  // reset_n and a plain RAM can be inferred.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fetch_pc    <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          instr_valid <= 1'b0;
          instruction <= '0;
          if (start) begin
            state       <= S_FETCH;
            fetch_pc    <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
          end
        end

        S_FETCH: begin
          if (branch_valid) begin
            // Redirect flushes the presented word and inserts a single bubble.
            fetch_pc    <= branch_target;
            instr_valid <= 1'b0;
            instruction <= '0;
          end else if (!stall) begin
            if (fetch_word == HALT_WORD) begin
              state       <= S_HALT;
              halted      <= 1'b1;
              instr_valid <= 1'b0;
              instruction <= '0;
            end else begin
              instruction <= fetch_word;
              instr_valid <= 1'b1;
              pc_out      <= fetch_pc;
              fetch_pc    <= fetch_pc + 1'b1;
              if (fetch_count != '1) begin
                fetch_count <= fetch_count + 1'b1;
              end
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          instruction <= '0;
        end
      endcase
    end
  end

endmodule
